// File: rtl/gpmc_csr_bank_pkg.sv
// Shared definitions for GPMC CSR banks: window geometry, register offsets and
// the offset decoder used by every bank instance.
package gpmc_csr_bank_pkg;

  localparam int WINDOW_BITS = 6;
  localparam int MAX_REGS    = 8;

  localparam logic [WINDOW_BITS-1:0] OFS_ID      = 6'h00;
  localparam logic [WINDOW_BITS-1:0] OFS_SCRATCH = 6'h02;
  localparam logic [WINDOW_BITS-1:0] OFS_STICKY  = 6'h04;
  localparam logic [WINDOW_BITS-1:0] OFS_MASK    = 6'h06;
  localparam logic [WINDOW_BITS-1:0] OFS_PULSE   = 6'h08;
  localparam logic [WINDOW_BITS-1:0] OFS_CTRL    = 6'h10;
  localparam logic [WINDOW_BITS-1:0] OFS_STATUS  = 6'h20;

  typedef enum logic [2:0] {
    SEL_NONE    = 3'd0,
    SEL_ID      = 3'd1,
    SEL_SCRATCH = 3'd2,
    SEL_STICKY  = 3'd3,
    SEL_MASK    = 3'd4,
    SEL_PULSE   = 3'd5,
    SEL_CTRL    = 3'd6,
    SEL_STATUS  = 3'd7
  } csr_sel_e;

  // Bit 0 is ignored; ctrl/status slots beyond the configured count decode to nothing.
  function automatic csr_sel_e decode_sel(input logic [WINDOW_BITS-1:0] ofs,
                                          input int n_ctrl, input int n_status);
    logic [WINDOW_BITS-1:0] word;
    csr_sel_e sel;
    word = {ofs[WINDOW_BITS-1:1], 1'b0};
    sel  = SEL_NONE;
    if (word == OFS_ID) begin
      sel = SEL_ID;
    end else if (word == OFS_SCRATCH) begin
      sel = SEL_SCRATCH;
    end else if (word == OFS_STICKY) begin
      sel = SEL_STICKY;
    end else if (word == OFS_MASK) begin
      sel = SEL_MASK;
    end else if (word == OFS_PULSE) begin
      sel = SEL_PULSE;
    end else if (word[5:4] == OFS_CTRL[5:4]) begin
      if (int'(word[3:1]) < n_ctrl) sel = SEL_CTRL;
      else sel = SEL_NONE;
    end else if (word[5:4] == OFS_STATUS[5:4]) begin
      if (int'(word[3:1]) < n_status) sel = SEL_STATUS;
      else sel = SEL_NONE;
    end else begin
      sel = SEL_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/gpmc_csr_bank_if.sv
// Host-side register access bus as presented by gpmc_sync.
interface gpmc_csr_bank_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  address_valid;
  logic [ADDR_WIDTH:0]   address;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  hit;

  modport master (
    output address_valid, address, wr_en, rd_en, wr_data,
    input  rd_data, hit
  );

  modport slave (
    input  address_valid, address, wr_en, rd_en, wr_data,
    output rd_data, hit
  );
endinterface

// File: rtl/csr_sticky_bits.sv
// Sticky event latch with write-1-to-clear, interrupt mask and registered irq.
// Reusable for any set of one-cycle error/event pulses.
module csr_sticky_bits #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] event_in,
  input  logic         clr_en,
  input  logic [W-1:0] clr,
  input  logic         mask_we,
  input  logic [W-1:0] mask_in,
  output logic [W-1:0] sticky,
  output logic [W-1:0] mask,
  output logic         irq
);

  logic [W-1:0] sticky_r;
  logic [W-1:0] mask_r;
  logic         irq_r;
  logic [W-1:0] clr_s;

  // Clear vector is only live during a write to the sticky register.
  always_comb begin
    clr_s = '0;
    if (clr_en) clr_s = clr;
    else clr_s = '0;
  end

  // Event set wins over a same-cycle clear; irq lags sticky/mask by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_r <= '0;
      mask_r   <= '0;
      irq_r    <= 1'b0;
    end else begin
      sticky_r <= (sticky_r & ~clr_s) | event_in;
      if (mask_we) mask_r <= mask_in;
      irq_r <= |(sticky_r & mask_r);
    end
  end

  assign sticky = sticky_r;
  assign mask   = mask_r;
  assign irq    = irq_r;

endmodule

// File: rtl/gpmc_csr_bank.sv
// Parametrised GPMC control/status register bank: ID, scratch, sticky events,
// irq mask, pulse strobes, control and status registers in a 64-byte window.
module gpmc_csr_bank
  import gpmc_csr_bank_pkg::*;
#(
  parameter int                         ADDR_WIDTH    = 16,
  parameter int                         DATA_WIDTH    = 16,
  parameter logic [ADDR_WIDTH:0]        BASE_ADDR     = '0,
  parameter logic [DATA_WIDTH-1:0]      ID_VALUE      = 16'hC10D,
  parameter logic [DATA_WIDTH-1:0]      SCRATCH_RESET = 16'h1234,
  parameter int                         N_CTRL        = 4,
  parameter int                         N_STATUS      = 4,
  parameter int                         N_EVENTS      = 8,
  parameter logic [N_CTRL*DATA_WIDTH-1:0] CTRL_RESET  = '0
) (
  input  logic                           gpmc_clk,
  input  logic                           gpmc_reset_n,
  gpmc_csr_bank_if.slave                 bus,
  output logic [N_CTRL*DATA_WIDTH-1:0]   ctrl,
  input  logic [N_STATUS*DATA_WIDTH-1:0] status,
  input  logic [N_EVENTS-1:0]            event_in,
  output logic [DATA_WIDTH-1:0]          pulse,
  output logic                           irq
);

  if (BASE_ADDR[WINDOW_BITS-1:0] != '0) begin : g_bad_base
    $error("gpmc_csr_bank: BASE_ADDR must be 64-byte aligned");
  end
  if (N_CTRL < 1 || N_CTRL > MAX_REGS || N_STATUS < 1 || N_STATUS > MAX_REGS ||
      N_EVENTS < 1 || N_EVENTS > DATA_WIDTH) begin : g_bad_size
    $error("gpmc_csr_bank: register counts out of range");
  end

  logic [WINDOW_BITS-1:0] ofs_s;
  logic                   win_hit_s;
  csr_sel_e               sel_s;
  logic [2:0]             idx_s;

  logic [DATA_WIDTH-1:0]  scratch_r;
  logic [DATA_WIDTH-1:0]  ctrl_r [N_CTRL];
  logic [DATA_WIDTH-1:0]  pulse_r;
  logic [DATA_WIDTH-1:0]  rd_data_r;
  logic                   hit_r;

  logic [DATA_WIDTH-1:0]  ctrl_view_s   [MAX_REGS];
  logic [DATA_WIDTH-1:0]  status_view_s [MAX_REGS];
  logic [DATA_WIDTH-1:0]  sticky_ext_s;
  logic [DATA_WIDTH-1:0]  mask_ext_s;
  logic [DATA_WIDTH-1:0]  rd_mux_s;
  logic [N_EVENTS-1:0]    sticky_s;
  logic [N_EVENTS-1:0]    mask_s;

  assign ofs_s     = bus.address[WINDOW_BITS-1:0];
  assign win_hit_s = (bus.address[ADDR_WIDTH:WINDOW_BITS] == BASE_ADDR[ADDR_WIDTH:WINDOW_BITS]);
  assign sel_s     = win_hit_s ? decode_sel(ofs_s, N_CTRL, N_STATUS) : SEL_NONE;
  assign idx_s     = ofs_s[3:1];

  csr_sticky_bits #(.W(N_EVENTS)) u_sticky (
    .clk      (gpmc_clk),
    .rst_n    (gpmc_reset_n),
    .event_in (event_in),
    .clr_en   (bus.wr_en && (sel_s == SEL_STICKY)),
    .clr      (bus.wr_data[N_EVENTS-1:0]),
    .mask_we  (bus.wr_en && (sel_s == SEL_MASK)),
    .mask_in  (bus.wr_data[N_EVENTS-1:0]),
    .sticky   (sticky_s),
    .mask     (mask_s),
    .irq      (irq)
  );

  // Scratch and control register writes; wr_en alone qualifies a write.
  always_ff @(posedge gpmc_clk or negedge gpmc_reset_n) begin
    if (!gpmc_reset_n) begin
      scratch_r <= SCRATCH_RESET;
      for (int i = 0; i < N_CTRL; i++) ctrl_r[i] <= CTRL_RESET[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      if (bus.wr_en && (sel_s == SEL_SCRATCH)) scratch_r <= bus.wr_data;
      for (int i = 0; i < N_CTRL; i++) begin
        if (bus.wr_en && (sel_s == SEL_CTRL) && (idx_s == 3'(i))) ctrl_r[i] <= bus.wr_data;
      end
    end
  end

  // Fixed-size views keep the 3-bit slot index in range whatever the counts.
  always_comb begin
    for (int i = 0; i < MAX_REGS; i++) begin
      ctrl_view_s[i]   = '0;
      status_view_s[i] = '0;
    end
    for (int i = 0; i < N_CTRL; i++)   ctrl_view_s[i]   = ctrl_r[i];
    for (int i = 0; i < N_STATUS; i++) status_view_s[i] = status[i*DATA_WIDTH +: DATA_WIDTH];
    sticky_ext_s = '0;
    mask_ext_s   = '0;
    sticky_ext_s[N_EVENTS-1:0] = sticky_s;
    mask_ext_s[N_EVENTS-1:0]   = mask_s;
  end

  // Read mux; anything not decoded (including misses) returns zero.
  always_comb begin
    rd_mux_s = '0;
    case (sel_s)
      SEL_ID:      rd_mux_s = ID_VALUE;
      SEL_SCRATCH: rd_mux_s = scratch_r;
      SEL_STICKY:  rd_mux_s = sticky_ext_s;
      SEL_MASK:    rd_mux_s = mask_ext_s;
      SEL_CTRL:    rd_mux_s = ctrl_view_s[idx_s];
      SEL_STATUS:  rd_mux_s = status_view_s[idx_s];
      default:     rd_mux_s = '0;
    endcase
  end

  // Registered read response and one-cycle pulse strobes.
  always_ff @(posedge gpmc_clk or negedge gpmc_reset_n) begin
    if (!gpmc_reset_n) begin
      rd_data_r <= '0;
      hit_r     <= 1'b0;
      pulse_r   <= '0;
    end else begin
      rd_data_r <= bus.address_valid ? rd_mux_s : '0;
      hit_r     <= bus.address_valid && win_hit_s;
      pulse_r   <= (bus.wr_en && (sel_s == SEL_PULSE)) ? bus.wr_data : '0;
    end
  end

  for (genvar g = 0; g < N_CTRL; g++) begin : g_ctrl_out
    assign ctrl[g*DATA_WIDTH +: DATA_WIDTH] = ctrl_r[g];
  end

  assign bus.rd_data = rd_data_r;
  assign bus.hit     = hit_r;
  assign pulse       = pulse_r;

endmodule

// File: tb/tb_gpmc_csr_bank.sv
// Scoreboard bench for gpmc_csr_bank: two banks (base 0x0000 and 0x0040),
// reads queue expectations that a monitor retires one cycle later.
module tb_gpmc_csr_bank;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam logic [63:0] CTRL_RST0 = 64'h4444_3333_2222_1111;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  gpmc_csr_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b0 ();
  gpmc_csr_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b1 ();

  logic [63:0] ctrl0, ctrl1, status0, status1;
  logic [7:0]  ev0, ev1;
  logic [15:0] pulse0, pulse1;
  logic        irq0, irq1;

  gpmc_csr_bank #(.BASE_ADDR(17'h00000), .CTRL_RESET(CTRL_RST0)) dut0 (
    .gpmc_clk(clk), .gpmc_reset_n(rst_n), .bus(b0), .ctrl(ctrl0),
    .status(status0), .event_in(ev0), .pulse(pulse0), .irq(irq0));

  gpmc_csr_bank #(.BASE_ADDR(17'h00040)) dut1 (
    .gpmc_clk(clk), .gpmc_reset_n(rst_n), .bus(b1), .ctrl(ctrl1),
    .status(status1), .event_in(ev1), .pulse(pulse1), .irq(irq1));

  typedef struct {
    int          id;
    logic [15:0] data;
    logic        hit;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int total = 0;
  int bad   = 0;
  int rd_id = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int d, input logic [15:0] e, input logic h);
    exp_t x;
    x.id = rd_id; x.data = e; x.hit = h;
    rd_id++;
    if (d == 0) q0.push_back(x);
    else q1.push_back(x);
  endtask

  task automatic rd(input int d, input logic [16:0] a, input logic [15:0] e, input logic h);
    push(d, e, h);
    if (d == 0) begin b0.address_valid = 1'b1; b0.rd_en = 1'b1; b0.address = a; end
    else begin b1.address_valid = 1'b1; b1.rd_en = 1'b1; b1.address = a; end
    step();
    b0.address_valid = 1'b0; b0.rd_en = 1'b0;
    b1.address_valid = 1'b0; b1.rd_en = 1'b0;
  endtask

  task automatic wr(input int d, input logic [16:0] a, input logic [15:0] v);
    if (d == 0) begin b0.wr_en = 1'b1; b0.address = a; b0.wr_data = v; end
    else begin b1.wr_en = 1'b1; b1.address = a; b1.wr_data = v; end
    step();
    b0.wr_en = 1'b0;
    b1.wr_en = 1'b0;
  endtask

  // Monitor: a read issued at an edge is retired at the following negedge.
  initial begin
    logic v0, v1;
    exp_t x;
    forever begin
      @(posedge clk);
      v0 = b0.address_valid;
      v1 = b1.address_valid;
      @(negedge clk);
      total++;
      if (v0) begin
        if (q0.size() == 0) begin
          bad++;
          $display("FAIL rd0_unexpected: got data=%h hit=%b with no expectation", b0.rd_data, b0.hit);
        end else begin
          x = q0.pop_front();
          if (b0.rd_data !== x.data || b0.hit !== x.hit) begin
            bad++;
            $display("FAIL rd#%0d bank0: got data=%h hit=%b expected data=%h hit=%b",
                     x.id, b0.rd_data, b0.hit, x.data, x.hit);
          end
        end
      end else if (b0.rd_data !== 16'h0000 || b0.hit !== 1'b0) begin
        bad++;
        $display("FAIL idle0: got data=%h hit=%b expected data=0000 hit=0", b0.rd_data, b0.hit);
      end
      total++;
      if (v1) begin
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL rd1_unexpected: got data=%h hit=%b with no expectation", b1.rd_data, b1.hit);
        end else begin
          x = q1.pop_front();
          if (b1.rd_data !== x.data || b1.hit !== x.hit) begin
            bad++;
            $display("FAIL rd#%0d bank1: got data=%h hit=%b expected data=%h hit=%b",
                     x.id, b1.rd_data, b1.hit, x.data, x.hit);
          end
        end
      end else if (b1.rd_data !== 16'h0000 || b1.hit !== 1'b0) begin
        bad++;
        $display("FAIL idle1: got data=%h hit=%b expected data=0000 hit=0", b1.rd_data, b1.hit);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    b0.address_valid = 1'b0; b0.address = '0; b0.wr_en = 1'b0; b0.rd_en = 1'b0; b0.wr_data = '0;
    b1.address_valid = 1'b0; b1.address = '0; b1.wr_en = 1'b0; b1.rd_en = 1'b0; b1.wr_data = '0;
    status0 = 64'hDDDD_CCCC_BBBB_AAAA;
    status1 = 64'h0;
    ev0 = 8'h00;
    ev1 = 8'h00;

    // Reset values, observed during reset before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rd_data", b0.rd_data, 16'h0000);
    chk("rst_hit", b0.hit, 1'b0);
    chk("rst_irq", irq0, 1'b0);
    chk("rst_pulse", pulse0, 16'h0000);
    chk("rst_ctrl", ctrl0, CTRL_RST0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // 1: fixed registers, ctrl reset image, ignored bit 0, empty slots
    rd(0, 17'h00000, 16'hC10D, 1'b1);
    rd(0, 17'h00002, 16'h1234, 1'b1);
    rd(0, 17'h00010, 16'h1111, 1'b1);
    rd(0, 17'h00011, 16'h1111, 1'b1);
    rd(0, 17'h00018, 16'h0000, 1'b1);
    rd(0, 17'h00008, 16'h0000, 1'b1);
    rd(0, 17'h00020, 16'hAAAA, 1'b1);
    rd(0, 17'h00026, 16'hDDDD, 1'b1);
    rd(0, 17'h0002E, 16'h0000, 1'b1);

    // 2: scratch write/readback, unmapped and out-of-window writes ignored
    wr(0, 17'h00002, 16'hBEEF);
    rd(0, 17'h00002, 16'hBEEF, 1'b1);
    wr(0, 17'h0003E, 16'hFFFF);
    wr(0, 17'h00018, 16'hFFFF);
    rd(0, 17'h0003E, 16'h0000, 1'b1);
    rd(0, 17'h00002, 16'hBEEF, 1'b1);
    chk("ctrl_untouched", ctrl0, CTRL_RST0);
    wr(0, 17'h00042, 16'h0000);
    rd(0, 17'h00042, 16'h0000, 1'b0);
    rd(0, 17'h00002, 16'hBEEF, 1'b1);

    // 3: sticky, mask, irq latency, W1C, set-beats-clear
    ev0 = 8'h08; step(); ev0 = 8'h00;
    rd(0, 17'h00004, 16'h0008, 1'b1);
    chk("irq_masked", irq0, 1'b0);
    wr(0, 17'h00006, 16'h0008);
    chk("irq_lag", irq0, 1'b0);
    step();
    chk("irq_set", irq0, 1'b1);
    rd(0, 17'h00006, 16'h0008, 1'b1);
    wr(0, 17'h00004, 16'h0008);
    chk("irq_clr_lag", irq0, 1'b1);
    step();
    chk("irq_cleared", irq0, 1'b0);
    rd(0, 17'h00004, 16'h0000, 1'b1);
    ev0 = 8'h09; step(); ev0 = 8'h00;
    rd(0, 17'h00004, 16'h0009, 1'b1);
    ev0 = 8'h08;
    wr(0, 17'h00004, 16'h0009);
    ev0 = 8'h00;
    rd(0, 17'h00004, 16'h0008, 1'b1);
    chk("irq_set_wins", irq0, 1'b1);
    wr(0, 17'h00004, 16'hFFFF);
    rd(0, 17'h00004, 16'h0000, 1'b1);
    chk("irq_all_clr", irq0, 1'b0);

    // 4: back-to-back pulses, then ctrl write
    chk("pulse_idle", pulse0, 16'h0000);
    b0.wr_en = 1'b1; b0.address = 17'h00008; b0.wr_data = 16'h0005;
    step();
    chk("pulse_1", pulse0, 16'h0005);
    step();
    chk("pulse_2", pulse0, 16'h0005);
    b0.wr_en = 1'b0;
    step();
    chk("pulse_end", pulse0, 16'h0000);
    rd(0, 17'h00008, 16'h0000, 1'b1);
    wr(0, 17'h00014, 16'hCAFE);
    chk("ctrl2_write", ctrl0, 64'h4444_CAFE_2222_1111);
    rd(0, 17'h00014, 16'hCAFE, 1'b1);

    // Status sampled at the address edge, not later
    status0 = 64'hDDDD_CCCC_1111_AAAA;
    push(0, 16'h1111, 1'b1);
    b0.address_valid = 1'b1; b0.address = 17'h00022;
    @(posedge clk);
    #1 status0 = 64'hDDDD_CCCC_2222_AAAA;
    #1 b0.address_valid = 1'b0;
    rd(0, 17'h00022, 16'h2222, 1'b1);

    // 5: second bank at 0x0040
    rd(1, 17'h00000, 16'h0000, 1'b0);
    rd(1, 17'h00040, 16'hC10D, 1'b1);
    status1 = 64'h0000_0000_A5A5_0000;
    rd(1, 17'h00062, 16'hA5A5, 1'b1);
    rd(0, 17'h00040, 16'h0000, 1'b0);
    wr(1, 17'h00042, 16'h5555);
    rd(1, 17'h00042, 16'h5555, 1'b1);
    rd(0, 17'h00002, 16'hBEEF, 1'b1);

    // 6: asynchronous reset mid-cycle
    ev0 = 8'h08; step(); ev0 = 8'h00;
    step();
    chk("irq_before_rst", irq0, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_ctrl", ctrl0, CTRL_RST0);
    chk("async_irq", irq0, 1'b0);
    chk("async_pulse", pulse0, 16'h0000);
    @(posedge clk);
    #2 rst_n = 1'b1;
    rd(0, 17'h00004, 16'h0000, 1'b1);
    rd(0, 17'h00006, 16'h0000, 1'b1);
    rd(0, 17'h00002, 16'h1234, 1'b1);
    rd(0, 17'h00014, 16'h3333, 1'b1);

    step();
    step();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
